// File: rtl/parity_pkg.sv
// Shared parity definitions for the parity stream checker family.
// Holds the mode encoding and the reference parity generation function.
package parity_pkg;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } par_mode_e;

    localparam int unsigned MAX_DATA_W = 64;

    // Data is zero-extended to MAX_DATA_W by the caller; zeros do not alter the XOR.
    function automatic logic par_gen(input logic [MAX_DATA_W-1:0] data, input logic mode);
        return (^data) ^ mode;
    endfunction

endpackage

// File: rtl/parity_calc.sv
// Combinational parity generator/checker for one data lane.
// gen is the parity to transmit; err flags a received parity mismatch.
module parity_calc
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    input  logic              rx_parity,
    input  logic              mode,
    output logic              gen,
    output logic              err
);

    logic [MAX_DATA_W-1:0] data_ext;

    always_comb begin
        data_ext               = '0;
        data_ext[DATA_W-1:0]   = data;
        gen                    = par_gen(data_ext, mode);
        err                    = gen ^ rx_parity;
    end

endmodule

// File: rtl/parity_stream_chk.sv
// Streaming parity generator/checker: one registered output stage with
// valid/ready handshakes, plus a saturating error counter and sticky flag.
module parity_stream_chk
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              odd_mode,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_parity,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_parity,
    output logic              out_error,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_sticky
);

    logic acc;
    logic calc_gen;
    logic calc_err;
    logic acc_err;
    logic cnt_sat;

    // The stage can take a new beat when empty or when its current beat leaves this cycle.
    assign in_ready = !out_valid | out_ready;
    assign acc      = in_valid & in_ready;
    assign acc_err  = acc & calc_err;
    assign cnt_sat  = &err_count;

    parity_calc #(
        .DATA_W (DATA_W)
    ) u_calc (
        .data      (in_data),
        .rx_parity (in_parity),
        .mode      (odd_mode),
        .gen       (calc_gen),
        .err       (calc_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_parity <= 1'b0;
            out_error  <= 1'b0;
        end else if (acc) begin
            out_valid  <= 1'b1;
            out_data   <= in_data;
            out_parity <= calc_gen;
            out_error  <= calc_err;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // A clear coinciding with an errored beat restarts the count at one so that error is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else if (clr) begin
            err_count  <= acc_err ? CNT_W'(1) : '0;
            err_sticky <= acc_err;
        end else if (acc_err) begin
            if (!cnt_sat) begin
                err_count <= err_count + CNT_W'(1);
            end
            err_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_parity_stream_chk.sv
// Self-checking bench for parity_stream_chk: directed scenario tasks plus a
// scoreboard that tracks every accepted beat through to delivery.
module tb_parity_stream_chk;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       odd_mode;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_parity;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_parity;
    logic       out_error;
    logic [7:0] err_count;
    logic       err_sticky;

    logic       s_in_ready;
    logic       s_out_valid;
    logic [7:0] s_out_data;
    logic       s_out_parity;
    logic       s_out_error;
    logic [1:0] s_err_count;
    logic       s_err_sticky;

    int n_vec       = 0;
    int n_err       = 0;
    int n_delivered = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       e;
    } beat_t;

    beat_t q[$];

    always #5 clk = ~clk;

    parity_stream_chk #(.DATA_W(8), .CNT_W(8)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .odd_mode   (odd_mode),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_parity  (in_parity),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_parity (out_parity),
        .out_error  (out_error),
        .err_count  (err_count),
        .err_sticky (err_sticky)
    );

    parity_stream_chk #(.DATA_W(8), .CNT_W(2)) u_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .odd_mode   (odd_mode),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (s_in_ready),
        .in_data    (in_data),
        .in_parity  (in_parity),
        .out_valid  (s_out_valid),
        .out_ready  (out_ready),
        .out_data   (s_out_data),
        .out_parity (s_out_parity),
        .out_error  (s_out_error),
        .err_count  (s_err_count),
        .err_sticky (s_err_sticky)
    );

    // Handshake signals are stable at the falling edge, so this sees what the next rising edge will act on.
    always @(negedge clk) begin
        beat_t b;
        if (rst_n === 1'b1) begin
            if (out_valid && out_ready) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected_beat got data=%h par=%b err=%b, no beat expected",
                             out_data, out_parity, out_error);
                end else begin
                    b = q.pop_front();
                    n_delivered++;
                    if ({out_data, out_parity, out_error} !== {b.d, b.p, b.e}) begin
                        n_err++;
                        $display("FAIL sb_beat got data=%h par=%b err=%b exp data=%h par=%b err=%b",
                                 out_data, out_parity, out_error, b.d, b.p, b.e);
                    end
                end
            end
            if (in_valid && in_ready) begin
                b.d = in_data;
                b.p = (^in_data) ^ odd_mode;
                b.e = (^in_data) ^ in_parity ^ odd_mode;
                q.push_back(b);
            end
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1; odd_mode = 1'b0; clr = 1'b0; in_valid = 1'b0;
        in_data = '0; in_parity = 1'b0; out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        n_vec++;
        if ({out_valid, out_data, out_parity, out_error, err_count, err_sticky, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_values got v=%b d=%h p=%b e=%b cnt=%h st=%b rdy=%b exp 0 00 0 0 00 0 1",
                     out_valid, out_data, out_parity, out_error, err_count, err_sticky, in_ready);
        end
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_even;
        odd_mode = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h55; in_parity = 1'b0;
        cyc();
        in_valid = 1'b0;
        n_vec++;
        if ({out_valid, out_data, out_parity, out_error, err_count} !== {1'b1, 8'h55, 1'b0, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL even_55 got v=%b d=%h p=%b e=%b cnt=%h exp 1 55 0 0 00",
                     out_valid, out_data, out_parity, out_error, err_count);
        end
        cyc();
    endtask

    task automatic test_odd_then_even;
        odd_mode = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h55; in_parity = 1'b0;
        cyc();
        odd_mode = 1'b0; in_data = 8'hF0; in_parity = 1'b1;
        n_vec++;
        if ({out_data, out_parity, out_error, err_count, err_sticky} !== {8'h55, 1'b1, 1'b1, 8'h01, 1'b1}) begin
            n_err++;
            $display("FAIL odd_55 got d=%h p=%b e=%b cnt=%h st=%b exp 55 1 1 01 1",
                     out_data, out_parity, out_error, err_count, err_sticky);
        end
        cyc();
        in_valid = 1'b0;
        n_vec++;
        if ({out_data, out_parity, out_error, err_count, err_sticky} !== {8'hF0, 1'b0, 1'b1, 8'h02, 1'b1}) begin
            n_err++;
            $display("FAIL even_f0 got d=%h p=%b e=%b cnt=%h st=%b exp f0 0 1 02 1",
                     out_data, out_parity, out_error, err_count, err_sticky);
        end
        cyc();
    endtask

    task automatic test_backpressure;
        int start;
        start = n_delivered;
        odd_mode = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h0F; in_parity = 1'b0;
        cyc();
        out_ready = 1'b0; in_data = 8'hAA;
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_ready_drop got %b exp 0", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            odd_mode = (i == 1);
            cyc();
            n_vec++;
            if ({out_valid, out_data, out_parity, out_error, in_ready} !== {1'b1, 8'h0F, 1'b0, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold[%0d] got v=%b d=%h p=%b e=%b rdy=%b exp 1 0f 0 0 0",
                         i, out_valid, out_data, out_parity, out_error, in_ready);
            end
        end
        odd_mode = 1'b0; out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_ready_rise got %b exp 1", in_ready);
        end
        cyc();
        in_valid = 1'b0;
        n_vec++;
        if ({out_valid, out_data} !== {1'b1, 8'hAA}) begin
            n_err++;
            $display("FAIL bp_load_aa got v=%b d=%h exp 1 aa", out_valid, out_data);
        end
        cyc();
        n_vec++;
        if ({out_valid, n_delivered - start} !== {1'b0, 32'd2}) begin
            n_err++;
            $display("FAIL bp_delivered got v=%b n=%0d exp v=0 n=2", out_valid, n_delivered - start);
        end
    endtask

    task automatic test_saturation;
        clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; odd_mode = 1'b0; in_data = 8'h01; in_parity = 1'b0;
            cyc();
            n_vec++;
            if ({s_err_count, err_count} !== {((i < 3) ? 2'(i + 1) : 2'd3), 8'(i + 1)}) begin
                n_err++;
                $display("FAIL sat_seq[%0d] got sat=%0d cnt=%0d exp sat=%0d cnt=%0d",
                         i, s_err_count, err_count, (i < 3) ? i + 1 : 3, i + 1);
            end
        end
        in_valid = 1'b0; clr = 1'b1;
        cyc();
        clr = 1'b0;
        n_vec++;
        if ({s_err_count, s_err_sticky, err_count, err_sticky} !== {2'd0, 1'b0, 8'h00, 1'b0}) begin
            n_err++;
            $display("FAIL clr_alone got sat=%0d sst=%b cnt=%0d st=%b exp 0 0 0 0",
                     s_err_count, s_err_sticky, err_count, err_sticky);
        end
    endtask

    task automatic test_clr_with_err;
        clr = 1'b1; in_valid = 1'b1; odd_mode = 1'b0; in_data = 8'h01; in_parity = 1'b0; out_ready = 1'b1;
        cyc();
        clr = 1'b0; in_valid = 1'b0;
        n_vec++;
        if ({err_count, err_sticky, s_err_count, s_err_sticky} !== {8'h01, 1'b1, 2'd1, 1'b1}) begin
            n_err++;
            $display("FAIL clr_with_err got cnt=%0d st=%b sat=%0d sst=%b exp 1 1 1 1",
                     err_count, err_sticky, s_err_count, s_err_sticky);
        end
        cyc();
    endtask

    task automatic test_reset_mid_stall;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; odd_mode = 1'b0; in_data = 8'h03; in_parity = 1'b1;
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        cyc();
        n_vec++;
        if ({out_valid, err_count, in_ready} !== {1'b1, 8'h05, 1'b0}) begin
            n_err++;
            $display("FAIL pre_reset_stall got v=%b cnt=%0d rdy=%b exp 1 5 0", out_valid, err_count, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({out_valid, out_data, out_parity, out_error, err_count, err_sticky, in_ready} !== {1'b1 ^ 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL async_reset got v=%b d=%h p=%b e=%b cnt=%0d st=%b rdy=%b exp 0 00 0 0 0 0 1",
                     out_valid, out_data, out_parity, out_error, err_count, err_sticky, in_ready);
        end
        q.delete();
        cyc();
        rst_n = 1'b1; out_ready = 1'b1;
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = 8'($urandom); in_parity = 1'($urandom); odd_mode = 1'($urandom);
            cyc();
            n_vec++;
            if ({out_valid, in_ready} !== 2'b11) begin
                n_err++;
                $display("FAIL b2b_rate[%0d] got v=%b rdy=%b exp 1 1", i, out_valid, in_ready);
            end
        end
        for (int i = 0; i < 60; i++) begin
            in_valid = 1'($urandom); out_ready = 1'($urandom);
            in_data = 8'($urandom); in_parity = 1'($urandom); odd_mode = 1'($urandom);
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cyc(); cyc(); cyc();
        n_vec++;
        if ({out_valid, q.size()} !== {1'b0, 32'd0}) begin
            n_err++;
            $display("FAIL drain got v=%b pending=%0d exp 0 0", out_valid, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_even();
        test_odd_then_even();
        test_backpressure();
        test_saturation();
        test_clr_with_err();
        test_reset_mid_stall();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
